up_ramcfg_initctl: RTL

UP_RAMCFG_INITCTL -- requirements
Module: up_ramcfg_initctl

---
 rtl/up_ramcfg_initctl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/up_ramcfg_initctl.sv
// Config-RAM front end: passes host up-protocol accesses through to the RAM macro
// and, on request, fills every RAM address with one value.
module up_ramcfg_initctl #(
    parameter int G_ADDR  = 10,
    parameter int G_WIDTH = 32,
    parameter int G_TMO   = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_start,
    input  logic [G_WIDTH-1:0] init_val,
    output logic               init_busy,
    output logic               init_done,
    output logic               init_err,
    input  logic               hupen,
    input  logic               hupws,
    input  logic               huprs,
    input  logic [G_ADDR-1:0]  hupa,
    input  logic [G_WIDTH-1:0] hupdi,
    output logic [G_WIDTH-1:0] hupdo,
    output logic               huprdy,
    output logic               upen,
    output logic               upws,
    output logic               uprs,
    output logic [G_ADDR-1:0]  upa,
    output logic [G_WIDTH-1:0] updi,
    input  logic [G_WIDTH-1:0] updo,
    input  logic               uprdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST,
        S_INIT_WR,
        S_INIT_GAP,
        S_INIT_END
    } state_t;

    localparam logic [G_ADDR-1:0] ADDR_LAST = '1;
    localparam logic [7:0]        TMO_LIM   = 8'(G_TMO);

    state_t             state_q, state_d;
    logic [G_ADDR-1:0]  addr_q, addr_d;
    logic [7:0]         tmo_q, tmo_d;
    logic [7:0]         tmo_inc;
    logic               pend_q, pend_d;
    logic               err_q, err_d;
    logic [G_WIDTH-1:0] val_q, val_d;
    logic [G_ADDR-1:0]  upa_q, upa_d;
    logic [G_WIDTH-1:0] updi_q, updi_d;
    logic               start_acc;

    // A start request is only honoured while no sweep is in progress.
    assign start_acc = init_start && ((state_q == S_IDLE) || (state_q == S_HOST));
    assign tmo_inc   = tmo_q + 8'd1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tmo_d   = tmo_q;
        pend_d  = pend_q;
        err_d   = err_q;
        val_d   = val_q;

        if (start_acc) begin
            val_d = init_val;
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (init_start || pend_q) begin
                    state_d = S_INIT_WR;
                    addr_d  = '0;
                    tmo_d   = '0;
                end else if (hupen) begin
                    state_d = S_HOST;
                end
            end
            S_HOST: begin
                if (init_start) begin
                    pend_d = 1'b1;
                end
                if (!hupen) begin
                    state_d = S_IDLE;
                end
            end
            S_INIT_WR: begin
                if (uprdy) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = S_INIT_END;
                    end else begin
                        addr_d  = addr_q + G_ADDR'(1);
                        state_d = S_INIT_GAP;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_LIM) begin
                        err_d   = 1'b1;
                        state_d = S_INIT_END;
                    end
                end
            end
            S_INIT_GAP: begin
                // One idle cycle lets the macro drop its request latch.
                tmo_d   = '0;
                state_d = S_INIT_WR;
            end
            S_INIT_END: begin
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address and data keep the last value driven so the macro pins stay quiet when idle.
    always_comb begin
        upa_d  = upa_q;
        updi_d = updi_q;
        case (state_q)
            S_HOST: begin
                upa_d  = hupa;
                updi_d = hupdi;
            end
            S_INIT_WR: begin
                upa_d  = addr_q;
                updi_d = val_q;
            end
            default: begin
                upa_d  = upa_q;
                updi_d = updi_q;
            end
        endcase
    end

    always_comb begin
        upen   = 1'b0;
        upws   = 1'b0;
        uprs   = 1'b0;
        upa    = upa_q;
        updi   = updi_q;
        huprdy = 1'b0;
        case (state_q)
            S_HOST: begin
                upen   = hupen;
                upws   = hupws;
                uprs   = huprs;
                upa    = hupa;
                updi   = hupdi;
                huprdy = uprdy;
            end
            S_INIT_WR: begin
                upen = 1'b1;
                upws = 1'b1;
                upa  = addr_q;
                updi = val_q;
            end
            default: begin
                upen = 1'b0;
            end
        endcase
    end

    assign hupdo     = updo;
    assign init_done = (state_q == S_INIT_END);
    assign init_err  = err_q;
    assign init_busy = pend_q || (state_q == S_INIT_WR) || (state_q == S_INIT_GAP)
                       || (state_q == S_INIT_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            tmo_q   <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            val_q   <= '0;
            upa_q   <= '0;
            updi_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            val_q   <= val_d;
            upa_q   <= upa_d;
            updi_q  <= updi_d;
        end
    end

endmodule
